// File: rtl/ring_buffer_ctl.sv
// rtl/ring_buffer_ctl.sv - single-clock ring buffer with count-based flags, overwrite mode, flush and registered read
module ring_buffer_ctl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_LEVEL  = 14,
    parameter int AE_LEVEL  = 2,
    parameter int OVERWRITE = 0,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             at_full;
    logic             at_empty;
    logic             rd_ok;
    logic             wr_ok;
    logic             evict;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign at_full  = (count == CW'(DEPTH));
    assign at_empty = (count == '0);
    assign rd_ok    = rd_en && !at_empty;
    assign wr_ok    = wr_en && (!at_full || rd_ok || (OVERWRITE != 0));
    // Write into a full buffer with no read: only reachable in overwrite mode, drops the oldest word.
    assign evict    = wr_ok && at_full && !rd_ok;

    assign full         = at_full;
    assign empty        = at_empty;
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    always_ff @(posedge clk) begin
        if (!rst && !flush && wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid  <= rd_ok;
            overflow  <= wr_en && at_full && !rd_ok;
            underflow <= rd_en && at_empty;
            if (rd_ok) begin
                rd_data <= mem[rd_ptr];
            end
            if (wr_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_ok || evict) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (wr_ok && !rd_ok && !evict) begin
                count <= count + CW'(1);
            end else if (rd_ok && !wr_ok) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ring_buffer_ctl.sv
// tb/tb_ring_buffer_ctl.sv - scoreboard bench for ring_buffer_ctl (DEPTH 16 drop, DEPTH 16 overwrite, DEPTH 12)
module tb_ring_buffer_ctl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;

    logic [7:0] rd_data0, rd_data1, rd_data2;
    logic       rd_valid0, rd_valid1, rd_valid2;
    logic       full0, full1, full2, empty0, empty1, empty2;
    logic       af0, af1, af2, ae0, ae1, ae2;
    logic [4:0] count0, count1;
    logic [3:0] count2;
    logic       ovf0, ovf1, ovf2, udf0, udf1, udf2;

    int         sel = 0;
    logic [7:0] o_rd_data;
    logic       o_rd_valid, o_full, o_empty, o_af, o_ae, o_ovf, o_udf;
    logic [4:0] o_count;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];
    logic       exp_valid, exp_ovf, exp_udf;
    logic [7:0] exp_d;

    always #5 clk = ~clk;

    ring_buffer_ctl #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .OVERWRITE(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(udf0));

    ring_buffer_ctl #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .OVERWRITE(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(udf1));

    ring_buffer_ctl #(.WIDTH(8), .DEPTH(12), .AF_LEVEL(10), .AE_LEVEL(2), .OVERWRITE(0)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .full(full2), .empty(empty2),
        .almost_full(af2), .almost_empty(ae2), .count(count2), .overflow(ovf2), .underflow(udf2));

    always_comb begin
        o_rd_data = rd_data0; o_rd_valid = rd_valid0; o_full = full0; o_empty = empty0;
        o_af = af0; o_ae = ae0; o_count = count0; o_ovf = ovf0; o_udf = udf0;
        if (sel == 1) begin
            o_rd_data = rd_data1; o_rd_valid = rd_valid1; o_full = full1; o_empty = empty1;
            o_af = af1; o_ae = ae1; o_count = count1; o_ovf = ovf1; o_udf = udf1;
        end else if (sel == 2) begin
            o_rd_data = rd_data2; o_rd_valid = rd_valid2; o_full = full2; o_empty = empty2;
            o_af = af2; o_ae = ae2; o_count = {1'b0, count2}; o_ovf = ovf2; o_udf = udf2;
        end
    end

    task automatic do_reset(input int s);
        sel = s;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_q.delete();
        exp_q.delete();
    endtask

    // Reference model: updates the buffer image and pushes expected read words, then applies one cycle.
    task automatic drive(input logic we, input logic [7:0] wd, input logic re);
        int         depth;
        logic       full_m, rd_ok_m, wr_ok_m;
        logic [7:0] lost;
        depth   = (sel == 2) ? 12 : 16;
        full_m  = (model_q.size() == depth);
        rd_ok_m = re && (model_q.size() != 0);
        wr_ok_m = we && (!full_m || rd_ok_m || (sel == 1));
        exp_ovf = we && full_m && !rd_ok_m;
        exp_udf = re && (model_q.size() == 0);
        exp_valid = rd_ok_m;
        if (rd_ok_m) exp_q.push_back(model_q.pop_front());
        if (wr_ok_m) begin
            if (full_m && !rd_ok_m) lost = model_q.pop_front();
            model_q.push_back(wd);
        end
        wr_en = we; wr_data = wd; rd_en = re;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(0);
        n_vec++; if (o_count !== 5'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", o_count); end
        n_vec++; if (o_empty !== 1'b1 || o_ae !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b%b exp=11", o_empty, o_ae); end
        n_vec++; if (o_full !== 1'b0 || o_af !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b%b exp=00", o_full, o_af); end
        n_vec++; if (o_rd_valid !== 1'b0 || o_rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd got=%b/%h exp=0/00", o_rd_valid, o_rd_data); end
        n_vec++; if (o_ovf !== 1'b0 || o_udf !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b%b exp=00", o_ovf, o_udf); end
    endtask

    task automatic test_fill_drain();
        do_reset(0);
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            n_vec++; if (o_count !== 5'(i)) begin n_err++; $display("FAIL fill_count got=%0d exp=%0d", o_count, i); end
            n_vec++; if (o_af !== (i >= 14) || o_ae !== (i <= 2)) begin n_err++; $display("FAIL fill_almost got=%b%b exp=%b%b", o_af, o_ae, i >= 14, i <= 2); end
            n_vec++; if (o_full !== (i == 16)) begin n_err++; $display("FAIL fill_full got=%b exp=%b", o_full, i == 16); end
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            n_vec++; if (o_rd_valid !== exp_valid) begin n_err++; $display("FAIL drain_valid got=%b exp=%b", o_rd_valid, exp_valid); end
            if (exp_valid) begin
                exp_d = exp_q.pop_front();
                n_vec++; if (o_rd_data !== exp_d) begin n_err++; $display("FAIL drain_data got=%h exp=%h", o_rd_data, exp_d); end
            end
        end
        n_vec++; if (o_empty !== 1'b1 || o_count !== 5'd0) begin n_err++; $display("FAIL drain_empty got=%b/%0d exp=1/0", o_empty, o_count); end
        drive(1'b0, 8'h00, 1'b0);
        n_vec++; if (o_rd_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid got=%b exp=0", o_rd_valid); end
    endtask

    task automatic test_overflow_drop();
        do_reset(0);
        for (int i = 1; i <= 16; i++) drive(1'b1, 8'(i), 1'b0);
        drive(1'b1, 8'hAA, 1'b0);
        n_vec++; if (o_ovf !== 1'b1) begin n_err++; $display("FAIL drop_ovf got=%b exp=1", o_ovf); end
        n_vec++; if (o_count !== 5'd16) begin n_err++; $display("FAIL drop_count got=%0d exp=16", o_count); end
        drive(1'b0, 8'h00, 1'b0);
        n_vec++; if (o_ovf !== 1'b0) begin n_err++; $display("FAIL drop_ovf_pulse got=%b exp=0", o_ovf); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            exp_d = exp_q.pop_front();
            n_vec++; if (o_rd_valid !== 1'b1 || o_rd_data !== exp_d) begin n_err++; $display("FAIL drop_data got=%b/%h exp=1/%h", o_rd_valid, o_rd_data, exp_d); end
        end
    endtask

    task automatic test_overwrite();
        do_reset(1);
        for (int i = 1; i <= 16; i++) drive(1'b1, 8'(i), 1'b0);
        drive(1'b1, 8'hAA, 1'b0);
        n_vec++; if (o_ovf !== exp_ovf) begin n_err++; $display("FAIL ow_ovf1 got=%b exp=%b", o_ovf, exp_ovf); end
        drive(1'b1, 8'hBB, 1'b0);
        n_vec++; if (o_ovf !== exp_ovf) begin n_err++; $display("FAIL ow_ovf2 got=%b exp=%b", o_ovf, exp_ovf); end
        n_vec++; if (o_count !== 5'd16 || o_full !== 1'b1) begin n_err++; $display("FAIL ow_count got=%0d/%b exp=16/1", o_count, o_full); end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            exp_d = exp_q.pop_front();
            n_vec++; if (o_rd_valid !== 1'b1 || o_rd_data !== exp_d) begin n_err++; $display("FAIL ow_data got=%b/%h exp=1/%h", o_rd_valid, o_rd_data, exp_d); end
            if (i == 0) begin
                n_vec++; if (o_rd_data !== 8'h03) begin n_err++; $display("FAIL ow_first got=%h exp=03", o_rd_data); end
            end
        end
        n_vec++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL ow_empty got=%b exp=1", o_empty); end
    endtask

    task automatic test_underflow();
        do_reset(0);
        drive(1'b1, 8'h55, 1'b1);
        n_vec++; if (o_udf !== exp_udf) begin n_err++; $display("FAIL udf_pulse got=%b exp=%b", o_udf, exp_udf); end
        n_vec++; if (o_rd_valid !== 1'b0) begin n_err++; $display("FAIL udf_valid got=%b exp=0", o_rd_valid); end
        n_vec++; if (o_count !== 5'd1) begin n_err++; $display("FAIL udf_count got=%0d exp=1", o_count); end
        drive(1'b0, 8'h00, 1'b1);
        exp_d = exp_q.pop_front();
        n_vec++; if (o_rd_valid !== 1'b1 || o_rd_data !== exp_d) begin n_err++; $display("FAIL udf_data got=%b/%h exp=1/%h", o_rd_valid, o_rd_data, exp_d); end
        n_vec++; if (o_udf !== 1'b0) begin n_err++; $display("FAIL udf_clear got=%b exp=0", o_udf); end
    endtask

    task automatic test_back_to_back(input int s);
        do_reset(s);
        for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 8'($urandom_range(0, 255)), 1'b1);
            n_vec++; if (o_count !== 5'd8) begin n_err++; $display("FAIL b2b_count sel=%0d got=%0d exp=8", s, o_count); end
            exp_d = exp_q.pop_front();
            n_vec++; if (o_rd_valid !== 1'b1 || o_rd_data !== exp_d) begin n_err++; $display("FAIL b2b_data sel=%0d got=%b/%h exp=1/%h", s, o_rd_valid, o_rd_data, exp_d); end
        end
    endtask

    task automatic test_flush_rst();
        do_reset(0);
        for (int i = 1; i <= 5; i++) drive(1'b1, 8'(i), 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        exp_d = exp_q.pop_front();
        n_vec++; if (o_rd_data !== exp_d) begin n_err++; $display("FAIL flush_pre got=%h exp=%h", o_rd_data, exp_d); end
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99; rd_en = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        model_q.delete(); exp_q.delete();
        n_vec++; if (o_count !== 5'd0 || o_empty !== 1'b1) begin n_err++; $display("FAIL flush_count got=%0d/%b exp=0/1", o_count, o_empty); end
        n_vec++; if (o_rd_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got=%b exp=0", o_rd_valid); end
        n_vec++; if (o_rd_data !== 8'h01) begin n_err++; $display("FAIL flush_hold got=%h exp=01", o_rd_data); end
        drive(1'b1, 8'h77, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        exp_d = exp_q.pop_front();
        n_vec++; if (o_rd_valid !== 1'b1 || o_rd_data !== exp_d) begin n_err++; $display("FAIL flush_after got=%b/%h exp=1/%h", o_rd_valid, o_rd_data, exp_d); end
        for (int i = 1; i <= 5; i++) drive(1'b1, 8'(i + 16), 1'b0);
        rst = 1'b1; wr_en = 1'b1; wr_data = 8'h99; rd_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        model_q.delete(); exp_q.delete();
        n_vec++; if (o_count !== 5'd0 || o_empty !== 1'b1 || o_ae !== 1'b1) begin n_err++; $display("FAIL rst_mid_count got=%0d/%b%b exp=0/11", o_count, o_empty, o_ae); end
        n_vec++; if (o_full !== 1'b0 || o_af !== 1'b0) begin n_err++; $display("FAIL rst_mid_full got=%b%b exp=00", o_full, o_af); end
        n_vec++; if (o_rd_valid !== 1'b0 || o_rd_data !== 8'h00) begin n_err++; $display("FAIL rst_mid_rd got=%b/%h exp=0/00", o_rd_valid, o_rd_data); end
        n_vec++; if (o_ovf !== 1'b0 || o_udf !== 1'b0) begin n_err++; $display("FAIL rst_mid_err got=%b%b exp=00", o_ovf, o_udf); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow_drop();
        test_overwrite();
        test_underflow();
        test_back_to_back(0);
        test_back_to_back(2);
        test_flush_rst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
